// File: rtl/i2c_pkg.sv
// Shared I2C constants used by the bus front end and the slave protocol FSM.
//   I2C_SYNC_STAGES    : metastability flops per pad line
//   I2C_FILT_LEN       : agreeing samples needed before a filtered level changes
//   I2C_TIMEOUT_CYCLES : clk cycles of SCL low while busy before a bus timeout
package i2c_pkg;

  localparam int I2C_SYNC_STAGES    = 2;
  localparam int I2C_FILT_LEN       = 2;
  localparam int I2C_TIMEOUT_CYCLES = 250000;

endpackage : i2c_pkg

// File: rtl/i2c_line_filter.sv
// Single-line pad conditioner: synchronizer chain followed by a spike filter.
// Ports:
//   clk   : system clock
//   reset : synchronous active-high reset (line idles high)
//   din   : raw asynchronous pad level
//   dout  : synchronized, filtered level
// The filtered level only changes after FILT_LEN consecutive synchronized
// samples disagree with it, so shorter pulses are swallowed.
module i2c_line_filter
  import i2c_pkg::*;
#(
  parameter int SYNC_STAGES = I2C_SYNC_STAGES,
  parameter int FILT_LEN    = I2C_FILT_LEN
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  localparam int CNT_W = $clog2(FILT_LEN + 1);
  localparam logic [CNT_W-1:0] FILT_MAX = CNT_W'(FILT_LEN);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   filt_reg;
  logic                   filt_next;
  logic [CNT_W-1:0]       cnt_reg;
  logic [CNT_W-1:0]       cnt_next;
  logic                   sample;

  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        always_ff @(posedge clk) begin
          if (reset) sync_reg[gi] <= 1'b1;
          else       sync_reg[gi] <= din;
        end
      end else begin : g_rest
        always_ff @(posedge clk) begin
          if (reset) sync_reg[gi] <= 1'b1;
          else       sync_reg[gi] <= sync_reg[gi-1];
        end
      end
    end
  endgenerate

  assign sample = sync_reg[SYNC_STAGES-1];

  // Counter tracks how many consecutive samples have disagreed with the
  // current filtered level; any agreeing sample restarts the count.
  always_comb begin
    filt_next = filt_reg;
    cnt_next  = '0;
    if (sample != filt_reg) begin
      if (cnt_reg + 1'b1 == FILT_MAX) begin
        filt_next = sample;
        cnt_next  = '0;
      end else begin
        cnt_next = cnt_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      filt_reg <= 1'b1;
      cnt_reg  <= '0;
    end else begin
      filt_reg <= filt_next;
      cnt_reg  <= cnt_next;
    end
  end

  assign dout = filt_reg;

endmodule : i2c_line_filter

// File: rtl/i2c_bus_frontend.sv
// I2C bus front end: conditions raw SCL/SDA and decodes bus events for the
// slave protocol FSM.
// Ports:
//   clk, reset       : system clock, synchronous active-high reset
//   scl_in, sda_in   : raw pad levels
//   scl_f, sda_f     : filtered line levels
//   scl_rise/fall    : one-cycle filtered SCL edge strobes
//   start_det        : one-cycle START / repeated START strobe
//   stop_det         : one-cycle STOP strobe
//   bus_busy         : high from START until STOP or timeout
//   bus_timeout      : one-cycle strobe, SCL stuck low too long while busy
module i2c_bus_frontend
  import i2c_pkg::*;
#(
  parameter int SYNC_STAGES    = I2C_SYNC_STAGES,
  parameter int FILT_LEN       = I2C_FILT_LEN,
  parameter int TIMEOUT_CYCLES = I2C_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic scl_in,
  input  logic sda_in,
  output logic scl_f,
  output logic sda_f,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic bus_busy,
  output logic bus_timeout
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES);

  logic            scl_p_reg;
  logic            sda_p_reg;
  logic            busy_reg;
  logic            busy_next;
  logic [TO_W-1:0] to_cnt_reg;
  logic [TO_W-1:0] to_cnt_next;

  i2c_line_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILT_LEN    (FILT_LEN)
  ) u_scl_filter (
    .clk   (clk),
    .reset (reset),
    .din   (scl_in),
    .dout  (scl_f)
  );

  i2c_line_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILT_LEN    (FILT_LEN)
  ) u_sda_filter (
    .clk   (clk),
    .reset (reset),
    .din   (sda_in),
    .dout  (sda_f)
  );

  // Strobes decode registered state only. START/STOP require SCL high in
  // both this and the previous cycle, so an SDA change coincident with an
  // SCL edge is never reported as a bus condition.
  assign scl_rise    =  scl_f & ~scl_p_reg;
  assign scl_fall    = ~scl_f &  scl_p_reg;
  assign start_det   =  sda_p_reg & ~sda_f & scl_f & scl_p_reg;
  assign stop_det    = ~sda_p_reg &  sda_f & scl_f & scl_p_reg;
  assign bus_timeout = (to_cnt_reg == TO_MAX);
  assign bus_busy    = busy_reg;

  always_comb begin
    busy_next = busy_reg;
    if (start_det)                    busy_next = 1'b1;
    else if (stop_det || bus_timeout) busy_next = 1'b0;
  end

  // Counting stops once busy drops, so a stuck bus yields a single timeout
  // pulse until a fresh START re-arms it.
  always_comb begin
    to_cnt_next = '0;
    if (busy_reg && !scl_f && !bus_timeout) to_cnt_next = to_cnt_reg + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      scl_p_reg  <= 1'b1;
      sda_p_reg  <= 1'b1;
      busy_reg   <= 1'b0;
      to_cnt_reg <= '0;
    end else begin
      scl_p_reg  <= scl_f;
      sda_p_reg  <= sda_f;
      busy_reg   <= busy_next;
      to_cnt_reg <= to_cnt_next;
    end
  end

endmodule : i2c_bus_frontend
